// File: rtl/irq_pkg.sv
// Shared constants and helpers for the interrupt request path.
// Used by the pending register and the encoder-side consumer.
package irq_pkg;

  localparam int N_IRQ = 8;
  localparam int IDX_W = 3;

  typedef logic [N_IRQ-1:0] irq_vec_t;
  typedef logic [IDX_W-1:0] irq_idx_t;

  localparam irq_vec_t PENDING_RST = '0;
  localparam irq_vec_t MASK_RST    = '0;
  localparam irq_vec_t PREV_RST    = '1;
  localparam irq_vec_t OVF_RST     = '0;

  function automatic irq_vec_t idx2vec(input logic en, input irq_idx_t idx);
    irq_vec_t v;
    v = '0;
    if (en) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// Per-line previous-value register and rising-edge vector.
// Reset to all ones so lines high at reset release do not fire.
module irq_edge_detect
  import irq_pkg::*;
#(
  parameter int N = N_IRQ
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] irq_i,
  output logic [N-1:0] rise_o
);

  logic [N-1:0] prev_q;
  logic [N-1:0] prev_d;

  assign prev_d = irq_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= PREV_RST;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise_o = irq_i & ~prev_q;

endmodule

// File: rtl/irq_pending_reg.sv
// Sticky pending/mask/overflow registers feeding the priority encoder.
// y and irq_out depend on registers only.
module irq_pending_reg
  import irq_pkg::*;
#(
  parameter int N    = N_IRQ,
  parameter bit EDGE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     irq_in,
  input  logic             mask_wr,
  input  logic [N-1:0]     mask_wdata,
  input  logic             ack,
  input  logic [IDX_W-1:0] ack_idx,
  input  logic [N-1:0]     ovf_clr,
  output logic [N-1:0]     y,
  output logic             irq_out,
  output logic [N-1:0]     pending,
  output logic [N-1:0]     mask,
  output logic [N-1:0]     overflow,
  output logic             ack_err
);

  logic [N-1:0] rise;
  logic [N-1:0] set_v;
  logic [N-1:0] clr_v;

  logic [N-1:0] pending_q;
  logic [N-1:0] pending_d;
  logic [N-1:0] mask_q;
  logic [N-1:0] mask_d;
  logic [N-1:0] ovf_q;
  logic [N-1:0] ovf_d;
  logic         ack_err_q;
  logic         ack_err_d;

  irq_edge_detect #(
    .N (N)
  ) u_edge (
    .clk    (clk),
    .rst    (rst),
    .irq_i  (irq_in),
    .rise_o (rise)
  );

  assign set_v = EDGE ? rise : irq_in;
  assign clr_v = idx2vec(ack, ack_idx);

  always_comb begin
    pending_d = (pending_q & ~clr_v) | set_v;
    mask_d    = mask_wr ? mask_wdata : mask_q;
    ack_err_d = ack & ~pending_q[ack_idx];
    ovf_d     = '0;
    // a lost edge beats a same-cycle software clear
    if (EDGE) begin
      ovf_d = (ovf_q & ~ovf_clr) | (rise & pending_q & ~clr_v);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= PENDING_RST;
      mask_q    <= MASK_RST;
      ovf_q     <= OVF_RST;
      ack_err_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
      ovf_q     <= ovf_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign pending  = pending_q;
  assign mask     = mask_q;
  assign overflow = ovf_q;
  assign ack_err  = ack_err_q;
  assign y        = pending_q & mask_q;
  assign irq_out  = |y;

endmodule
